// File: rtl/rt_gray_pkg.sv
// Shared types for the Gray counter sequencer: FSM state encoding and
// command direction values.
package rt_gray_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic DIR_INC = 1'b0;
    localparam logic DIR_DEC = 1'b1;

endpackage

// File: rtl/rt_gray_cnt_ctrl_bin2gray.sv
// Purely combinational binary-to-Gray converter. The parent registers the
// result on the same edge as the binary value it was derived from.
module rt_bin2gray #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/rt_gray_cnt_ctrl.sv
// Command-driven binary/Gray counter sequencer: accepts start/len/dir over a
// valid/ready handshake, then steps once per unstalled RUN cycle.
module rt_gray_cnt_ctrl
    import rt_gray_pkg::*;
#(
    parameter int PARAM_BIT_NUM = 32
) (
    input  logic                     rt_i_clk,
    input  logic                     rt_i_rst_n,
    input  logic                     rt_i_cmd_vld,
    output logic                     rt_o_cmd_rdy,
    input  logic                     rt_i_cmd_dir,
    input  logic [PARAM_BIT_NUM-1:0] rt_i_cmd_start,
    input  logic [PARAM_BIT_NUM-1:0] rt_i_cmd_len,
    input  logic                     rt_i_stall,
    input  logic                     rt_i_abort,
    output logic [PARAM_BIT_NUM-1:0] rt_o_cnt_bin,
    output logic [PARAM_BIT_NUM-1:0] rt_o_cnt_gray,
    output logic                     rt_o_busy,
    output logic                     rt_o_done,
    output logic                     rt_o_aborted
);

    localparam int N = PARAM_BIT_NUM;
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_t         state;
    logic           cmd_dir;
    logic [N-1:0]   cmd_start;
    logic [N-1:0]   cmd_len;
    logic [N-1:0]   remaining;
    logic [N-1:0]   cnt_bin;
    logic [N-1:0]   cnt_gray;
    logic [N-1:0]   next_bin;
    logic [N-1:0]   next_gray;
    logic           aborted;

    // Abort takes priority, so neither a load nor a step may reach the count.
    always_comb begin
        next_bin = cnt_bin;
        case (state)
            ST_LOAD: begin
                if (!rt_i_abort) begin
                    next_bin = cmd_start;
                end
            end
            ST_RUN: begin
                if (!rt_i_abort && !rt_i_stall) begin
                    next_bin = (cmd_dir == DIR_DEC) ? (cnt_bin - ONE) : (cnt_bin + ONE);
                end
            end
            default: begin
                next_bin = cnt_bin;
            end
        endcase
    end

    rt_bin2gray #(.WIDTH(N)) u_bin2gray (
        .bin  (next_bin),
        .gray (next_gray)
    );

    always_ff @(posedge rt_i_clk or negedge rt_i_rst_n) begin
        if (!rt_i_rst_n) begin
            state     <= ST_IDLE;
            cmd_dir   <= DIR_INC;
            cmd_start <= '0;
            cmd_len   <= '0;
            remaining <= '0;
            cnt_bin   <= '0;
            cnt_gray  <= '0;
            aborted   <= 1'b0;
        end else begin
            cnt_bin  <= next_bin;
            cnt_gray <= next_gray;
            aborted  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rt_i_cmd_vld) begin
                        cmd_dir   <= rt_i_cmd_dir;
                        cmd_start <= rt_i_cmd_start;
                        cmd_len   <= rt_i_cmd_len;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (rt_i_abort) begin
                        aborted <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        remaining <= cmd_len;
                        state     <= (cmd_len == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (rt_i_abort) begin
                        aborted <= 1'b1;
                        state   <= ST_IDLE;
                    end else if (!rt_i_stall) begin
                        remaining <= remaining - ONE;
                        if (remaining == ONE) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rt_o_cmd_rdy  = (state == ST_IDLE);
    assign rt_o_busy     = (state == ST_LOAD) || (state == ST_RUN);
    assign rt_o_done     = (state == ST_DONE);
    assign rt_o_aborted  = aborted;
    assign rt_o_cnt_bin  = cnt_bin;
    assign rt_o_cnt_gray = cnt_gray;

endmodule

// File: tb/tb_rt_gray_cnt_ctrl.sv
// Directed scoreboard bench for rt_gray_cnt_ctrl at N = 8: each driven cycle
// queues its expected outputs, popped and compared one cycle later.
module tb_rt_gray_cnt_ctrl;

    localparam int N = 8;

    typedef struct packed {
        logic [N-1:0] bin;
        logic [N-1:0] gray;
        logic         rdy;
        logic         busy;
        logic         done;
        logic         aborted;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         cmd_vld;
    logic         cmd_rdy;
    logic         cmd_dir;
    logic [N-1:0] cmd_start;
    logic [N-1:0] cmd_len;
    logic         stall;
    logic         abort;
    logic [N-1:0] cnt_bin;
    logic [N-1:0] cnt_gray;
    logic         busy;
    logic         done;
    logic         aborted;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks;
    int    errors;

    rt_gray_cnt_ctrl #(.PARAM_BIT_NUM(N)) dut (
        .rt_i_clk       (clk),
        .rt_i_rst_n     (rst_n),
        .rt_i_cmd_vld   (cmd_vld),
        .rt_o_cmd_rdy   (cmd_rdy),
        .rt_i_cmd_dir   (cmd_dir),
        .rt_i_cmd_start (cmd_start),
        .rt_i_cmd_len   (cmd_len),
        .rt_i_stall     (stall),
        .rt_i_abort     (abort),
        .rt_o_cnt_bin   (cnt_bin),
        .rt_o_cnt_gray  (cnt_gray),
        .rt_o_busy      (busy),
        .rt_o_done      (done),
        .rt_o_aborted   (aborted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [N-1:0] to_gray(input logic [N-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Independent decode: binary bit i is the XOR of all Gray bits at or above i.
    function automatic logic [N-1:0] gray_to_bin(input logic [N-1:0] g);
        logic [N-1:0] b;
        for (int i = 0; i < N; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    function automatic exp_t mk(input logic [N-1:0] b, input logic [N-1:0] g,
                                input logic r, input logic bz, input logic d, input logic a);
        exp_t e;
        e.bin = b; e.gray = g; e.rdy = r; e.busy = bz; e.done = d; e.aborted = a;
        return e;
    endfunction

    task automatic checkOutput();
        exp_t  e;
        string t;
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("[TB] FAIL scoreboard_empty: observed 0 entries, expected at least 1");
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            assert (cnt_bin === e.bin) else begin
                errors++; $error("[TB] FAIL %s bin: observed %h expected %h", t, cnt_bin, e.bin);
            end
            checks++;
            assert (cnt_gray === e.gray) else begin
                errors++; $error("[TB] FAIL %s gray: observed %h expected %h", t, cnt_gray, e.gray);
            end
            checks++;
            assert (gray_to_bin(cnt_gray) === cnt_bin) else begin
                errors++; $error("[TB] FAIL %s gray_decode: observed %h expected %h", t, gray_to_bin(cnt_gray), cnt_bin);
            end
            checks++;
            assert (cmd_rdy === e.rdy) else begin
                errors++; $error("[TB] FAIL %s rdy: observed %b expected %b", t, cmd_rdy, e.rdy);
            end
            checks++;
            assert (busy === e.busy) else begin
                errors++; $error("[TB] FAIL %s busy: observed %b expected %b", t, busy, e.busy);
            end
            checks++;
            assert (done === e.done) else begin
                errors++; $error("[TB] FAIL %s done: observed %b expected %b", t, done, e.done);
            end
            checks++;
            assert (aborted === e.aborted) else begin
                errors++; $error("[TB] FAIL %s aborted: observed %b expected %b", t, aborted, e.aborted);
            end
        end
    endtask

    task automatic applyStimulus(input logic v, input logic d, input logic [N-1:0] s,
                                 input logic [N-1:0] l, input logic st, input logic ab,
                                 input exp_t e, input string t);
        cmd_vld   = v;
        cmd_dir   = d;
        cmd_start = s;
        cmd_len   = l;
        stall     = st;
        abort     = ab;
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic checkNow(input exp_t e, input string t);
        exp_q.push_back(e);
        tag_q.push_back(t);
        checkOutput();
    endtask

    logic [N-1:0] g_inc[6];
    logic [N-1:0] b_dec[4];
    logic [N-1:0] g_dec[4];
    logic [N-1:0] b;

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        cmd_vld   = 1'b0;
        cmd_dir   = 1'b0;
        cmd_start = '0;
        cmd_len   = '0;
        stall     = 1'b0;
        abort     = 1'b0;
        g_inc = '{8'h02, 8'h06, 8'h07, 8'h05, 8'h04, 8'h0C};
        b_dec = '{8'h01, 8'h00, 8'hFF, 8'hFE};
        g_dec = '{8'h01, 8'h00, 8'h80, 8'h81};

        #3;
        checkNow(mk(8'h00, 8'h00, 1, 0, 0, 0), "reset_state");
        #9 rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, mk(8'h00, 8'h00, 1, 0, 0, 0), "idle_after_reset");

        $display("[TB] increment run: start 03 len 5");
        applyStimulus(1, 0, 8'h03, 8'h05, 0, 0, mk(8'h00, 8'h00, 0, 1, 0, 0), "inc_load");
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, mk(8'h03, g_inc[0], 0, 1, 0, 0), "inc_start");
        for (int k = 1; k <= 5; k++) begin
            b = 8'h03 + k[N-1:0];
            applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, mk(b, g_inc[k], 0, k != 5, k == 5, 0), "inc_step");
        end
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, mk(8'h08, 8'h0C, 1, 0, 0, 0), "inc_idle");

        $display("[TB] decrement wrap: start 01 len 3");
        applyStimulus(1, 1, 8'h01, 8'h03, 0, 0, mk(8'h08, 8'h0C, 0, 1, 0, 0), "dec_load");
        for (int k = 0; k <= 3; k++) begin
            applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, mk(b_dec[k], g_dec[k], 0, k != 3, k == 3, 0), "dec_step");
        end
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, mk(8'hFE, 8'h81, 1, 0, 0, 0), "dec_idle");

        $display("[TB] zero length: start A5");
        applyStimulus(1, 0, 8'hA5, 8'h00, 0, 0, mk(8'hFE, 8'h81, 0, 1, 0, 0), "zero_load");
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, mk(8'hA5, 8'hF7, 0, 0, 1, 0), "zero_done");
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, mk(8'hA5, 8'hF7, 1, 0, 0, 0), "zero_idle");

        $display("[TB] stall and abort: start 10 len 10");
        applyStimulus(1, 0, 8'h10, 8'h0A, 0, 0, mk(8'hA5, 8'hF7, 0, 1, 0, 0), "sa_load");
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, mk(8'h10, to_gray(8'h10), 0, 1, 0, 0), "sa_start");
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, mk(8'h11, to_gray(8'h11), 0, 1, 0, 0), "sa_step1");
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, mk(8'h12, to_gray(8'h12), 0, 1, 0, 0), "sa_step2");
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, mk(8'h13, to_gray(8'h13), 0, 1, 0, 0), "sa_step3");
        applyStimulus(0, 0, 8'h00, 8'h00, 1, 0, mk(8'h13, to_gray(8'h13), 0, 1, 0, 0), "sa_stall1");
        applyStimulus(0, 0, 8'h00, 8'h00, 1, 0, mk(8'h13, to_gray(8'h13), 0, 1, 0, 0), "sa_stall2");
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, mk(8'h14, to_gray(8'h14), 0, 1, 0, 0), "sa_step4");
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, mk(8'h15, to_gray(8'h15), 0, 1, 0, 0), "sa_step5");
        applyStimulus(0, 0, 8'h00, 8'h00, 1, 1, mk(8'h15, to_gray(8'h15), 1, 0, 0, 1), "sa_abort");
        applyStimulus(0, 0, 8'h00, 8'h00, 1, 1, mk(8'h15, to_gray(8'h15), 1, 0, 0, 0), "sa_idle_ignores_abort");

        $display("[TB] abort during load keeps previous count");
        applyStimulus(1, 0, 8'h77, 8'h04, 0, 0, mk(8'h15, to_gray(8'h15), 0, 1, 0, 0), "al_load");
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 1, mk(8'h15, to_gray(8'h15), 1, 0, 0, 1), "al_abort");
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, mk(8'h15, to_gray(8'h15), 1, 0, 0, 0), "al_idle");

        $display("[TB] reset during run");
        applyStimulus(1, 0, 8'h20, 8'h08, 0, 0, mk(8'h15, to_gray(8'h15), 0, 1, 0, 0), "rr_load");
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, mk(8'h20, to_gray(8'h20), 0, 1, 0, 0), "rr_start");
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, mk(8'h21, to_gray(8'h21), 0, 1, 0, 0), "rr_step1");
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, mk(8'h22, to_gray(8'h22), 0, 1, 0, 0), "rr_step2");
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, mk(8'h23, to_gray(8'h23), 0, 1, 0, 0), "rr_step3");
        #2 rst_n = 1'b0;
        #1;
        checkNow(mk(8'h00, 8'h00, 1, 0, 0, 0), "rr_async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, mk(8'h00, 8'h00, 1, 0, 0, 0), "rr_after_release");
        end

        $display("[TB] back-to-back with cmd_vld held");
        applyStimulus(1, 0, 8'h40, 8'h02, 0, 0, mk(8'h00, 8'h00, 0, 1, 0, 0), "bb1_load");
        applyStimulus(1, 1, 8'h05, 8'h01, 0, 0, mk(8'h40, to_gray(8'h40), 0, 1, 0, 0), "bb1_start");
        applyStimulus(1, 1, 8'h05, 8'h01, 0, 0, mk(8'h41, to_gray(8'h41), 0, 1, 0, 0), "bb1_step1");
        applyStimulus(1, 1, 8'h05, 8'h01, 0, 0, mk(8'h42, to_gray(8'h42), 0, 0, 1, 0), "bb1_done");
        applyStimulus(1, 1, 8'h05, 8'h01, 0, 0, mk(8'h42, to_gray(8'h42), 1, 0, 0, 0), "bb1_idle");
        applyStimulus(1, 1, 8'h05, 8'h01, 0, 0, mk(8'h42, to_gray(8'h42), 0, 1, 0, 0), "bb2_accept");
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, mk(8'h05, to_gray(8'h05), 0, 1, 0, 0), "bb2_start");
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, mk(8'h04, to_gray(8'h04), 0, 0, 1, 0), "bb2_done");
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, mk(8'h04, to_gray(8'h04), 1, 0, 0, 0), "bb2_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
